fir_tdm: RTL
============

# fir_tdm

Parametrised, time-multiplexed FIR filter: one shared multiplier computes an NTAPS-tap convolution over NTAPS clock cycles per input sample. Coefficients are runtime-loadable through a write port. Input and output use a valid/ready handshake. It sits in the demodulator datapath in place of fixed-coefficient, fully parallel FIR stages wherever the sample rate is far below the clock rate.

## Interface
- DATA_W, 32: sample width, signed, for both input and output.
- COEF_W, 16: coefficient width, signed two's complement.
- NTAPS, 17: number of taps; legal range is 2..256.
- SHIFT, 16: arithmetic right shift applied to the accumulator before output (number of fractional coefficient bits).
- Derived values:
  - AW = clog2(NTAPS).
  - ACC_W = DATA_W + COEF_W + AW.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- s_valid, in, 1: input sample valid.
- s_ready, out, 1: block can accept a sample.
- s_data, in, DATA_W: input sample.
- m_valid, out, 1: one-cycle pulse marking a valid output.
- m_data, out, DATA_W: filtered output. Held until the next m_valid.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, AW: tap index. Index 0 weights the newest sample.
- coef_data, in, COEF_W: coefficient value.
- busy, out, 1: high while a convolution is in progress (the inverse of s_ready).

## Operation
- Storage:
  - Delay line x[0..NTAPS-1], with x[0] the newest sample, implemented as a circular buffer plus a write pointer.
  - Coefficient file h[0..NTAPS-1].
  - One ACC_W accumulator.
- State machine:
  - IDLE:
    - s_ready = 1.
    - On s_valid, the sample is written into the delay line (the oldest sample is discarded), the accumulator is cleared, the tap counter is set to 0, and the state goes to MAC.
  - MAC:
    - Each cycle: acc += h[k] * x[k], then k increments.
    - After k = NTAPS-1 the state goes to OUT.
  - OUT:
    - m_data <= sat_or_wrap(acc >>> SHIFT).
    - m_valid <= 1 for one cycle.
    - The state goes to IDLE.
- Result: y[n] = (Σ_{k=0}^{NTAPS-1} h[k]·x[n-k]) >>> SHIFT, accumulated at full precision with no intermediate rounding. The shift is arithmetic (truncation toward −∞).
- There is no output backpressure. The downstream stage must capture m_data on m_valid.
- Coefficient writes:
  - Accepted only in IDLE.
  - Writes during MAC or OUT are ignored.
  - Writes with coef_addr ≥ NTAPS are ignored.
  - A write and a sample accept on the same edge both take effect, and that sample uses the new coefficient.
- Reset clears all of the following:
  - the delay line, all coefficients, the accumulator and the pointers;
  - the state, which returns to IDLE;
  - the outputs: m_valid = 0, m_data = 0, s_ready = 1, busy = 0.
- Reset asserted during MAC or OUT aborts the computation, and no m_valid is produced.

## Timing
- Let E0 be the accept edge (s_valid && s_ready).
- MAC occupies the NTAPS cycles following E0.
- m_valid is high in the single cycle after edge E0 + NTAPS + 1.
- s_ready:
  - Goes low after E0.
  - Is high again in the same cycle that m_valid is high, so a new sample can be accepted on the edge that ends the m_valid cycle.
- Throughput is one sample per NTAPS + 1 cycles. With NTAPS = 17, back-to-back samples produce an m_valid every 18 cycles.
- The multiply-accumulate is a single combinational stage feeding the accumulator register; the accumulator has no extra pipeline latency.
- s_data is sampled only on the accept edge. Changes at any other time have no effect.

## Configuration
- FIR_SAT_EN defined:
  - If the shifted accumulator exceeds the DATA_W signed range, m_data clamps to 2^(DATA_W−1)−1 or −2^(DATA_W−1).
- FIR_SAT_EN undefined:
  - m_data is the low DATA_W bits of the shifted accumulator (two's-complement wrap).
  - The saturation logic is not synthesised.

## Test plan
- Reset values:
  - Assert rst for 3 cycles.
  - Expect m_valid = 0, m_data = 0, s_ready = 1, busy = 0.
  - Then feed the sample 1000 and expect m_data = 0, because all coefficients are zero.
- Impulse response (NTAPS = 17, SHIFT = 16):
  - Load h = 166, 376, 964, 2062, 3636, 5468, 7202, 8445, 8897, 8445, 7202, 5468, 3636, 2062, 964, 376, 166.
  - Feed 65536 followed by 16 zeros.
  - Expect the 17 outputs to equal h[0..16] in order.
  - Expect each m_valid exactly 18 cycles after its accept edge.
- Handshake:
  - Hold s_valid = 1 continuously with incrementing data.
  - Expect exactly one accept per 18 cycles, no sample skipped or duplicated, and s_ready = 0 throughout MAC.
- Ignored coefficient writes:
  - Write h[0] = 0x7FFF while in MAC, and also write to coef_addr = 20.
  - Expect the next impulse output to be unchanged (166).
  - Expect the same write issued in IDLE to take effect immediately.
- Saturation:
  - Load all taps with 32767 and feed 17 samples of 0x7FFFFFFF.
  - With FIR_SAT_EN defined, expect the final m_data = 0x7FFFFFFF.
  - With FIR_SAT_EN undefined, expect the low 32 bits of the shifted sum.
- Reset mid-MAC:
  - Assert rst 5 cycles after an accept.
  - Expect no m_valid, s_ready = 1 on the following cycle, and the delay line cleared (the next impulse response starts from zero history).

Source files
------------

// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed FIR filter; one shared multiplier runs NTAPS MAC cycles per sample.
// Define FIR_SAT_EN to saturate the output; otherwise the shifted accumulator wraps to DATA_W bits.
module fir_tdm #(
    parameter int  DATA_W = 32,
    parameter int  COEF_W = 16,
    parameter int  NTAPS  = 17,
    parameter int  SHIFT  = 16,
    localparam int AW     = $clog2(NTAPS),
    localparam int ACC_W  = DATA_W + COEF_W + AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy
);

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0]        x_mem [NTAPS];
    logic signed [COEF_W-1:0]        h_mem [NTAPS];
    logic signed [ACC_W-1:0]         acc;
    logic        [AW-1:0]            wr_ptr;
    logic        [AW-1:0]            rd_ptr;
    logic        [AW-1:0]            tap;

    logic                            accept;
    logic                            coef_ok;
    logic        [AW-1:0]            wr_ptr_new;
    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         acc_sum;
    logic        [DATA_W-1:0]        y;

    assign s_ready = (state_q == IDLE);
    assign busy    = ~s_ready;
    assign accept  = s_ready & s_valid;
    assign coef_ok = coef_we & s_ready & (coef_addr <= LAST);

    // The newest sample sits at wr_ptr; older samples follow at increasing addresses.
    assign wr_ptr_new = (wr_ptr == '0) ? LAST : wr_ptr - AW'(1);

    assign prod    = h_mem[tap] * x_mem[rd_ptr];
    assign acc_sum = acc + {{AW{prod[DATA_W+COEF_W-1]}}, prod};

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0]      acc_shift;
    logic        [ACC_W-DATA_W:0] head;

    assign acc_shift = acc >>> SHIFT;
    assign head      = acc_shift[ACC_W-1:DATA_W-1];

    // The value fits only when every bit above the output sign bit repeats it.
    always_comb begin
        if (head == '0 || head == '1) begin
            y = acc_shift[DATA_W-1:0];
        end else if (acc_shift[ACC_W-1]) begin
            y = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign y = acc[SHIFT +: DATA_W];
`endif

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_valid) state_d = MAC;
            MAC:     if (tap == LAST) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay line and coefficients are flops, not RAM, so reset clears every entry.
            for (int i = 0; i < NTAPS; i++) begin
                x_mem[i] <= '0;
                h_mem[i] <= '0;
            end
            acc     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tap     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            m_valid <= 1'b0;
            if (coef_ok) begin
                h_mem[coef_addr] <= coef_data;
            end
            if (accept) begin
                x_mem[wr_ptr_new] <= s_data;
                wr_ptr            <= wr_ptr_new;
                rd_ptr            <= wr_ptr_new;
                acc               <= '0;
                tap               <= '0;
            end
            if (state_q == MAC) begin
                acc    <= acc_sum;
                tap    <= tap + AW'(1);
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            if (state_q == OUT) begin
                m_data  <= y;
                m_valid <= 1'b1;
            end
        end
    end

endmodule
